// File: rtl/ex_flag_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_flag_stage
//  Purpose  : EX/MEM pipeline register with {Z,V,N} flag update, illegal-op
//             sticky error and optional same-cycle flag forwarding
//             (macro EX_FLAG_FWD_EN).
//  Revision : 1.0  initial release
// ============================================================================
module ex_flag_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [3:0]  aluop,
  input  logic [15:0] aluin1,
  input  logic [15:0] aluin2,
  input  logic [15:0] aluout,
  input  logic        alu_err,
  input  logic [3:0]  dst_reg,
  input  logic        reg_wen_in,
  output logic        out_valid,
  output logic [15:0] out_result,
  output logic [3:0]  out_dst,
  output logic        out_wen,
  output logic [2:0]  flags,
  output logic [2:0]  flags_fwd,
  output logic        err_sticky
);

  localparam logic [3:0] c_OP_ADD    = 4'd0;
  localparam logic [3:0] c_OP_SUB    = 4'd1;
  localparam logic [3:0] c_OP_XOR    = 4'd2;
  localparam logic [3:0] c_OP_SLL    = 4'd4;
  localparam logic [3:0] c_OP_SRA    = 4'd5;
  localparam logic [3:0] c_OP_ROR    = 4'd6;

  logic        w_accept;
  logic        w_err_capture;
  logic        w_z;
  logic        w_n;
  logic        w_v;
  logic [2:0]  w_flags_next;
  logic        w_unused_ok;

  logic        r_valid;
  logic [15:0] r_result;
  logic [3:0]  r_dst;
  logic        r_wen;
  logic [2:0]  r_flags;
  logic        r_err;

  assign w_accept      = in_valid & ~stall & ~flush & ~alu_err;
  assign w_err_capture = in_valid &  alu_err & ~stall & ~flush;

  assign w_z = (aluout == 16'h0000);
  assign w_n = aluout[15];

  // Only operand sign bits matter for overflow detection.
  assign w_unused_ok = ^{aluin1[14:0], aluin2[14:0]};

  always_comb begin
    w_v          = 1'b0;
    w_flags_next = r_flags;
    if (w_accept) begin
      case (aluop)
        c_OP_ADD: begin
          w_v          = (aluin1[15] == aluin2[15]) & (aluout[15] != aluin1[15]);
          w_flags_next = {w_z, w_v, w_n};
        end
        c_OP_SUB: begin
          w_v          = (aluin1[15] != aluin2[15]) & (aluout[15] != aluin1[15]);
          w_flags_next = {w_z, w_v, w_n};
        end
        c_OP_XOR, c_OP_SLL, c_OP_SRA, c_OP_ROR: begin
          w_flags_next = {w_z, r_flags[1:0]};
        end
        default: begin
          w_flags_next = r_flags;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= 16'h0000;
      r_dst    <= 4'h0;
      r_wen    <= 1'b0;
      r_flags  <= 3'b000;
      r_err    <= 1'b0;
    end else if (flush) begin
      // Flush wins over stall: bubble out, payload and flags untouched.
      r_valid <= 1'b0;
      r_wen   <= 1'b0;
    end else if (!stall) begin
      r_valid <= w_accept;
      r_wen   <= w_accept & reg_wen_in;
      if (w_accept) begin
        r_result <= aluout;
        r_dst    <= dst_reg;
      end
      r_flags <= w_flags_next;
      if (w_err_capture) begin
        r_err <= 1'b1;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_dst    = r_dst;
  assign out_wen    = r_wen;
  assign flags      = r_flags;
  assign err_sticky = r_err;

`ifdef EX_FLAG_FWD_EN
  assign flags_fwd = w_flags_next;
`else
  assign flags_fwd = r_flags;
`endif

endmodule
`default_nettype wire

// File: doc/ex_flag_stage.md
EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

Interface
REQ-001 SHALL have ports; clock and reset first; one per line:
  clk  input  1  sole clock; all state updates on rising edge
  rst_n  input  1  reset, synchronous, active-low
  in_valid  input  1  EX-stage instruction present this cycle
  stall  input  1  hold EX/MEM register and flags
  flush  input  1  kill the EX-stage instruction
  aluop  input  4  ALU opcode: 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8 LLB, 9 LHB
  aluin1  input  16  ALU operand 1 (sign used for V)
  aluin2  input  16  ALU operand 2 (sign used for V)
  aluout  input  16  ALU result for the same cycle
  alu_err  input  1  ALU reports illegal aluop
  dst_reg  input  4  destination register index
  reg_wen_in  input  1  instruction writes the register file
  out_valid  output  1  EX/MEM register holds a live instruction
  out_result  output  16  registered aluout
  out_dst  output  4  registered dst_reg
  out_wen  output  1  registered reg_wen_in, gated by out_valid
  flags  output  3  architectural flags {Z,V,N}
  flags_fwd  output  3  flags as seen by a branch in the following cycle
  err_sticky  output  1  set once any accepted instruction had alu_err
REQ-002 SHALL have no parameters.

Function
REQ-003 Accept = in_valid & ~stall & ~flush & ~alu_err; accepted instruction appears on out_* exactly 1 cycle later.
REQ-004 On accept: out_valid=1, out_result=aluout, out_dst=dst_reg, out_wen=reg_wen_in.
REQ-005 No accept and no stall: out_valid=0, out_wen=0; out_result/out_dst hold the previous value.
REQ-006 stall=1 (flush=0): all registered outputs and flags hold unchanged.
REQ-007 flush=1 overrides stall: out_valid=0, out_wen=0, no flag update that cycle.
REQ-008 Flag values from aluout: Z = (aluout==0); N = aluout[15]; V for ADD = (a15==b15)&(r15!=a15); V for SUB = (a15!=b15)&(r15!=a15).
REQ-009 Flag update on accept only: ADD/SUB write Z,V,N; XOR/SLL/SRA/ROR write Z only, V,N hold; RED/PADDSB/LLB/LHB write none.
REQ-010 in_valid & alu_err & ~stall & ~flush: out_valid=0, flags unchanged, err_sticky<=1.
REQ-011 err_sticky SHALL clear only on reset; alu_err with in_valid=0 SHALL be ignored.
REQ-012 flags_fwd SHALL follow EX_FLAG_FWD_EN (REQ-016/017).
REQ-013 No combinational path from any input to out_valid, out_result, out_dst, out_wen, flags or err_sticky.

Reset
REQ-014 rst_n=0 at a clock edge: out_valid=0, out_wen=0, out_result=16'h0000, out_dst=4'h0, flags=3'b000, err_sticky=0.
REQ-015 Reset SHALL override stall, flush and in_valid; an instruction in flight when reset is sampled is dropped with no flag update.

Configuration
REQ-016 Macro EX_FLAG_FWD_EN defined: flags_fwd = the flag value being written this cycle (REQ-009 result when accepting, else flags), combinationally.
REQ-017 Macro undefined: flags_fwd = flags (registered); no input-to-output combinational path anywhere.

Verification
REQ-018 Bench SHALL cover:
  ADD, aluin1=16'h7FFF, aluin2=16'h0001, aluout=16'h8000, accept -> next cycle out_result=8000, out_valid=1, flags={Z0,V1,N1}.
  SUB, aluin1=aluin2=16'h1234, aluout=0, then XOR with aluout=16'h0F0F -> flags 3'b100 after SUB, then {Z0,V0,N0} after XOR (V,N held from SUB, i.e. 0).
  LLB, aluout=16'h11FF following ADD that set flags 3'b011 -> flags stay 3'b011, out_result=11FF.
  stall=1 and flush=1 together with valid ADD -> out_valid=0, flags unchanged; stall alone -> all outputs held 3 cycles.
  aluop=4'hF, alu_err=1, in_valid=1 -> out_valid=0, err_sticky=1, stays 1 after 10 idle cycles until rst_n=0.
  With EX_FLAG_FWD_EN: ADD aluout=0 accepted -> flags_fwd=3'b100 in same cycle, flags=3'b100 next cycle; without macro, flags_fwd lags by 1 cycle.
